fifo_uart_drain: RTL and testbench



---
 rtl/fifo_uart_drain_if.sv | 10 +
 rtl/fifo_uart_drain.sv | 148 ++++++++++++++
 tb/tb_fifo_uart_drain.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_drain_if.sv
// FIFO read-side handshake between the sample FIFO and the UART drain.
// master: the drain issues reads; slave: the FIFO supplies empty/q.
interface fifo_uart_drain_if;
    logic       rdreq;
    logic       empty;
    logic [7:0] q;

    modport master (output rdreq, input empty, input q);
    modport slave  (input rdreq, output empty, output q);
endinterface

// File: rtl/fifo_uart_drain.sv
// Pops one byte at a time from the sample FIFO and sends it as 8N1 UART, LSB first.
// Counts transmitted bytes and pulses frame_done after each 0x0A.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | tx high, waiting for enable and a non-empty FIFO
// S_READ  | one-cycle rdreq pulse
// S_LATCH | FIFO data valid, captured into the shift register
// S_START | start bit (tx low) for BAUD_DIV cycles
// S_DATA  | eight data bits, BAUD_DIV cycles each
// S_STOP  | stop bit (tx high); byte counted on its last cycle
module fifo_uart_drain #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    fifo_uart_drain_if.master         fifo,
    output logic                      tx,
    output logic                      busy,
    output logic [15:0]               byte_cnt,
    output logic                      frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        tx_q, tx_d;
    logic        rdreq_q, rdreq_d;
    logic        busy_q, busy_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        baud_last;

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_cnt_d   = byte_cnt_q;
        frame_done_d = 1'b0;
        baud_last    = (baud_cnt_q == DIV_LAST);

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo.empty) state_d = S_READ;
            end
            S_READ: state_d = S_LATCH;
            S_LATCH: begin
                shift_d    = fifo.q;
                byte_d     = fifo.q;
                baud_cnt_d = 16'd0;
                state_d    = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_cnt_d = 16'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_cnt_d   = 16'd0;
                    byte_cnt_d   = byte_cnt_q + 16'd1;
                    frame_done_d = (byte_q == 8'h0A);
                    state_d      = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they move on the entering edge.
        rdreq_d = (state_d == S_READ);
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            baud_cnt_q   <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_q       <= 8'd0;
            tx_q         <= 1'b1;
            rdreq_q      <= 1'b0;
            busy_q       <= 1'b0;
            byte_cnt_q   <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            tx_q         <= tx_d;
            rdreq_q      <= rdreq_d;
            busy_q       <= busy_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo.rdreq = rdreq_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byte_cnt   = byte_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: queue-backed FIFO model, per-cycle expected UART waveform
// derived from the frame layout (2 fetch cycles, start, 8 data bits, stop).
module tb_fifo_uart_drain;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int BYTE_CYC = 10 * DIV + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        tx, busy, frame_done;
    logic [15:0] byte_cnt;

    fifo_uart_drain_if fif ();

    fifo_uart_drain #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo       (fif),
        .tx         (tx),
        .busy       (busy),
        .byte_cnt   (byte_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          last_rd = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [7:0]  fifo_mem[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Normal-mode FIFO: q valid the cycle after rdreq, empty registered.
    always @(posedge clk) begin
        if (fif.rdreq === 1'b1) begin
            chk("rd_not_empty", 32'(fifo_mem.size() > 0), 32'd1);
            if (fifo_mem.size() > 0) fif.q <= fifo_mem.pop_front();
        end
        fif.empty <= (fifo_mem.size() == 0);
    end

    function automatic logic exp_tx(input logic [7:0] b, input int k);
        if (k < 2)           return 1'b1;
        if (k < 2 + DIV)     return 1'b0;
        if (k < 2 + 9 * DIV) return b[(k - 2 - DIV) / DIV];
        return 1'b1;
    endfunction

    // Follows one byte from its rdreq to the IDLE cycle after the stop bit.
    task automatic xfer(input logic [7:0] b, input int drop_k, input int exp_gap, output int wait_n);
        @(negedge clk);
        wait_n = 0;
        while (fif.rdreq !== 1'b1 && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
        end
        chk("rdreq_seen", 32'(fif.rdreq), 32'd1);
        if (fif.rdreq !== 1'b1) return;
        if (exp_gap > 0) chk("start_gap", 32'(cyc - last_rd), 32'(exp_gap));
        last_rd = cyc;
        for (int k = 0; k < BYTE_CYC - 1; k++) begin
            if (k == drop_k) enable = 1'b0;
            chk("tx", 32'(tx), 32'(exp_tx(b, k)));
            chk("busy", 32'(busy), 32'd1);
            chk("rdreq_pulse", 32'(fif.rdreq), 32'(k == 0));
            chk("frame_done_low", 32'(frame_done), 32'd0);
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 16'd1;
        chk("byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
        chk("frame_done", 32'(frame_done), 32'(b == 8'h0A));
        chk("busy_end", 32'(busy), 32'd0);
        chk("tx_idle", 32'(tx), 32'd1);
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_rdreq"}, 32'(fif.rdreq), 32'd0);
            chk({tag, "_tx"}, 32'(tx), 32'd1);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int         w;
        int         n;
        logic [7:0] frm[$];
        logic [7:0] bv;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdreq", 32'(fif.rdreq), 32'd0);
        chk("rst_cnt", 32'(byte_cnt), 32'd0);
        chk("rst_frame", 32'(frame_done), 32'd0);
        reset = 1'b0;
        enable = 1'b1;

        // single byte
        fifo_mem.push_back(8'hA5);
        xfer(8'hA5, -1, 0, w);

        // CR/LF frame, back to back
        fifo_mem.push_back(8'h12);
        fifo_mem.push_back(8'h0D);
        fifo_mem.push_back(8'h0A);
        xfer(8'h12, -1, 0, w);
        xfer(8'h0D, -1, BYTE_CYC, w);
        xfer(8'h0A, -1, BYTE_CYC, w);

        // random frames of samples followed by CR/LF
        for (int f = 0; f < 3; f++) begin
            frm.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
            frm.push_back(8'h0D);
            frm.push_back(8'h0A);
            foreach (frm[i]) fifo_mem.push_back(frm[i]);
            foreach (frm[i]) xfer(frm[i], -1, (i == 0) ? 0 : BYTE_CYC, w);
            idle_check($urandom_range(1, 20), "gap");
        end

        // long empty period, then latency from empty deasserting
        idle_check(500, "empty");
        fifo_mem.push_back(8'h55);
        w = 0;
        while (fif.empty !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("empty_drop", 32'(fif.empty), 32'd0);
        xfer(8'h55, -1, 0, w);
        chk("rd_latency", 32'(w), 32'd0);

        // enable dropped during data bit 3 (k = 2 + DIV + 3*DIV + 3)
        fifo_mem.push_back(8'h3C);
        bv = 8'($urandom_range(0, 255));
        fifo_mem.push_back(bv);
        fifo_mem.push_back(8'h0A);
        xfer(8'h3C, 2 + 4 * DIV + 3, 0, w);
        idle_check(300, "disabled");
        chk("held_bytes", 32'(fifo_mem.size()), 32'd2);
        enable = 1'b1;
        xfer(bv, -1, 0, w);
        xfer(8'h0A, -1, BYTE_CYC, w);

        // reset mid-byte
        fifo_mem.push_back(8'hFF);
        w = 0;
        while (fif.rdreq !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ff_rdreq", 32'(fif.rdreq), 32'd1);
        repeat (50) @(negedge clk);
        chk("ff_data_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt", 32'(byte_cnt), 32'd0);
        chk("abort_frame", 32'(frame_done), 32'd0);
        exp_cnt = 16'd0;
        bv = 8'($urandom_range(0, 255));
        fifo_mem.push_back(bv);
        xfer(bv, -1, 0, w);

        // counter wrap
        @(negedge clk);
        force dut.byte_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.byte_cnt_q;
        @(negedge clk);
        chk("cnt_preload", 32'(byte_cnt), 32'hFFFF);
        exp_cnt = 16'hFFFF;
        bv = 8'($urandom_range(0, 255));
        fifo_mem.push_back(bv);
        xfer(bv, -1, 0, w);
        chk("cnt_wrapped", 32'(byte_cnt), 32'd0);

        idle_check(5, "tail");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
